// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions for the bit-serial subtractor: FSM state
// encoding and the bit-counter width helper.
package serial_subtractor_pkg;

  // Controller states; the encoding is shared with the sequencing logic.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // The counter must be able to reach WIDTH itself, hence width+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow is generated when a=0,b=1, or propagated when a==b.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, d = a - b - bin, LSB first, one bit per
// clock. A single full_subtractor cell plus a borrow flop is iterated WIDTH
// times. Optional signed-overflow output is enabled by defining
// SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             w_diff;
  logic             w_bout;

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;
  assign ovf = r_ovf;
`endif

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign d     = r_d;
  assign bout  = r_bout;

  // The single arithmetic cell, fed from the operand LSBs and the borrow flop.
  full_subtractor u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_diff),
    .bout (w_bout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: accept in IDLE, WIDTH shift cycles, one finish cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_LAST) w_state_next = FIN;
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath and registered status outputs; d/bout only move in FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_ready <= (w_state_next == IDLE);
      r_busy  <= (w_state_next == SHIFT);
      r_done  <= (r_state == FIN);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          // Written as shift-or so WIDTH=1 needs no special slice.
          r_res <= (r_res >> 1) | (WIDTH'(w_diff) << (WIDTH - 1));
          r_br  <= w_bout;
          r_cnt <= r_cnt + 1'b1;
        end
        FIN: begin
          r_d    <= r_res;
          r_bout <= r_br;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Capture operand sign bits at accept; evaluate overflow together with d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
      end
      if (r_state == FIN) begin
        r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ r_res[WIDTH-1]);
      end
    end
  end
`endif

endmodule
